// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, ALU ops,
// immediate formats, instruction classes and the decoded control word.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_MULWAIT   = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_TRAP      = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_MUL     = 3'd5,
        CLS_ILLEGAL = 3'd6
    } cls_e;

    localparam logic [1:0] A_RS1   = 2'd0;
    localparam logic [1:0] A_PC    = 2'd1;
    localparam logic [1:0] A_ZERO  = 2'd2;
    localparam logic       B_RS2   = 1'b0;
    localparam logic       B_IMM   = 1'b1;
    localparam logic [1:0] NPC_SEQ = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_JAL = 2'd2;
    localparam logic [1:0] NPC_JR  = 2'd3;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_LW   = 7'b0000011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_I_JALR = 7'b1100111;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_SB     = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_UJ     = 7'b1101111;

    typedef struct packed {
        cls_e       cls;
        alu_op_e    alu_op;
        logic [1:0] a_sel;
        logic       b_sel;
        imm_sel_e   imm_sel;
        logic [1:0] npc_sel;
        logic       writes_rd;
    } ctrl_t;

    // Only the register form may turn func_3=000 into SUB; ADDI never becomes SUBI.
    function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt, input logic is_reg);
        alu_op_e op;
        case (f3)
            3'b000:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_field_decoder.sv
// Combinational opcode/func decode into an instruction class and datapath control word.
// Optional RV32M_EN: R-type with func_7_bit_0=1 decodes as a multiply/divide, otherwise illegal.
module ctrl_field_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func_3,
    input  logic       func_7_bit_6,
    input  logic       func_7_bit_0,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl     = '0;
        ctrl.cls = CLS_ILLEGAL;
        case (opcode)
            OP_R: begin
                if (func_7_bit_0) begin
`ifdef RV32M_EN
                    ctrl.cls       = CLS_MUL;
                    ctrl.writes_rd = 1'b1;
`else
                    ctrl.cls       = CLS_ILLEGAL;
`endif
                end else begin
                    ctrl.cls       = CLS_ALU;
                    ctrl.alu_op    = arith_op(func_3, func_7_bit_6, 1'b1);
                    ctrl.writes_rd = 1'b1;
                end
            end
            OP_I_ALU: begin
                ctrl.cls       = CLS_ALU;
                ctrl.alu_op    = arith_op(func_3, func_7_bit_6, 1'b0);
                ctrl.b_sel     = B_IMM;
                ctrl.imm_sel   = IMM_I;
                ctrl.writes_rd = 1'b1;
            end
            OP_I_LW: begin
                ctrl.cls       = CLS_LOAD;
                ctrl.alu_op    = ALU_ADD;
                ctrl.b_sel     = B_IMM;
                ctrl.imm_sel   = IMM_I;
                ctrl.writes_rd = 1'b1;
            end
            OP_S: begin
                ctrl.cls     = CLS_STORE;
                ctrl.alu_op  = ALU_ADD;
                ctrl.b_sel   = B_IMM;
                ctrl.imm_sel = IMM_S;
            end
            OP_SB: begin
                // ALU compares rs1 against rs2; the target comes from the B immediate.
                ctrl.cls     = CLS_BRANCH;
                ctrl.alu_op  = ALU_SUB;
                ctrl.b_sel   = B_RS2;
                ctrl.imm_sel = IMM_B;
                ctrl.npc_sel = NPC_BR;
            end
            OP_I_JALR: begin
                ctrl.cls       = CLS_JUMP;
                ctrl.alu_op    = ALU_ADD;
                ctrl.b_sel     = B_IMM;
                ctrl.imm_sel   = IMM_I;
                ctrl.npc_sel   = NPC_JR;
                ctrl.writes_rd = 1'b1;
            end
            OP_UJ: begin
                ctrl.cls       = CLS_JUMP;
                ctrl.alu_op    = ALU_ADD;
                ctrl.a_sel     = A_PC;
                ctrl.b_sel     = B_IMM;
                ctrl.imm_sel   = IMM_J;
                ctrl.npc_sel   = NPC_JAL;
                ctrl.writes_rd = 1'b1;
            end
            OP_AUIPC: begin
                ctrl.cls       = CLS_ALU;
                ctrl.alu_op    = ALU_ADD;
                ctrl.a_sel     = A_PC;
                ctrl.b_sel     = B_IMM;
                ctrl.imm_sel   = IMM_U;
                ctrl.writes_rd = 1'b1;
            end
            OP_LUI: begin
                ctrl.cls       = CLS_ALU;
                ctrl.alu_op    = ALU_PASS_B;
                ctrl.a_sel     = A_ZERO;
                ctrl.b_sel     = B_IMM;
                ctrl.imm_sel   = IMM_U;
                ctrl.writes_rd = 1'b1;
            end
            default: ctrl.cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with imem/dmem handshakes,
// timeouts and sticky traps. Optional RV32M_EN adds the MULWAIT state and mul_start/mul_done.
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int ALU_OP_W    = 4,
    parameter int IMM_SEL_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic [2:0]           func_3,
    input  logic                 func_7_bit_6,
    input  logic                 func_7_bit_0,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    input  logic                 mul_done,
    output logic                 imem_req,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 write,
    output logic                 load,
    output logic                 store,
    output logic                 branch,
    output logic [1:0]           alu_operand_a_selector,
    output logic                 alu_operand_b_selector,
    output logic [IMM_SEL_W-1:0] immediate_selector,
    output logic [1:0]           next_pc_selector,
    output logic [ALU_OP_W-1:0]  alu_operations_selector,
    output logic                 mul_start,
    output logic                 illegal_instr,
    output logic                 mem_fault,
    output logic                 busy
);

    // Counter value seen in the last permitted wait cycle.
    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

    state_e               state_reg, state_next;
    logic [7:0]           wait_cnt_reg;
    ctrl_t                dec_ctrl, ctrl_reg, cur_ctrl;
    logic                 limit_hit, timeout_fault, decode_illegal, sel_live;

    logic                 imem_req_reg, pc_write_reg, write_reg, load_reg, store_reg, branch_reg;
    logic [1:0]           a_sel_reg, npc_sel_reg;
    logic                 b_sel_reg;
    logic [IMM_SEL_W-1:0] imm_sel_reg;
    logic [ALU_OP_W-1:0]  alu_op_reg;
    logic                 illegal_reg, mem_fault_reg, busy_reg;

    ctrl_field_decoder u_decoder (
        .opcode       (opcode),
        .func_3       (func_3),
        .func_7_bit_6 (func_7_bit_6),
        .func_7_bit_0 (func_7_bit_0),
        .ctrl         (dec_ctrl)
    );

    // While in DECODE the latched word is not yet loaded, so look through to the decoder.
    assign cur_ctrl       = (state_reg == ST_DECODE) ? dec_ctrl : ctrl_reg;
    assign limit_hit      = (wait_cnt_reg >= WAIT_LIMIT);
    assign decode_illegal = (state_reg == ST_DECODE) && (dec_ctrl.cls == CLS_ILLEGAL);
    assign sel_live       = state_next inside {ST_EXECUTE, ST_MEMORY, ST_MULWAIT, ST_WRITEBACK};

    always_comb begin
        state_next    = state_reg;
        timeout_fault = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                if (imem_ready) begin
                    state_next = ST_DECODE;
                end else if (limit_hit) begin
                    state_next    = ST_TRAP;
                    timeout_fault = 1'b1;
                end
            end
            ST_DECODE: state_next = decode_illegal ? ST_TRAP : ST_EXECUTE;
            ST_EXECUTE: begin
                case (ctrl_reg.cls)
                    CLS_LOAD, CLS_STORE: state_next = ST_MEMORY;
`ifdef RV32M_EN
                    CLS_MUL:             state_next = ST_MULWAIT;
`endif
                    default:             state_next = ST_WRITEBACK;
                endcase
            end
            ST_MEMORY: begin
                if (dmem_ready) begin
                    state_next = ST_WRITEBACK;
                end else if (limit_hit) begin
                    state_next    = ST_TRAP;
                    timeout_fault = 1'b1;
                end
            end
`ifdef RV32M_EN
            ST_MULWAIT: if (mul_done) state_next = ST_WRITEBACK;
`endif
            ST_WRITEBACK: state_next = ST_FETCH;
            default:      state_next = ST_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_FETCH;
            wait_cnt_reg  <= '0;
            ctrl_reg      <= '0;
            imem_req_reg  <= 1'b1;
            pc_write_reg  <= 1'b0;
            write_reg     <= 1'b0;
            load_reg      <= 1'b0;
            store_reg     <= 1'b0;
            branch_reg    <= 1'b0;
            a_sel_reg     <= '0;
            b_sel_reg     <= 1'b0;
            imm_sel_reg   <= '0;
            npc_sel_reg   <= '0;
            alu_op_reg    <= '0;
            illegal_reg   <= 1'b0;
            mem_fault_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg) begin
                wait_cnt_reg <= '0;
            end else if (wait_cnt_reg != 8'hFF) begin
                wait_cnt_reg <= wait_cnt_reg + 8'd1;
            end
            if (state_reg == ST_DECODE) begin
                ctrl_reg <= dec_ctrl;
            end
            // Outputs are registered against the state being entered so they line up with it.
            imem_req_reg <= (state_next == ST_FETCH);
            pc_write_reg <= (state_next == ST_WRITEBACK);
            write_reg    <= (state_next == ST_WRITEBACK) && cur_ctrl.writes_rd;
            load_reg     <= (state_next == ST_MEMORY) && (cur_ctrl.cls == CLS_LOAD);
            store_reg    <= (state_next == ST_MEMORY) && (cur_ctrl.cls == CLS_STORE);
            branch_reg   <= (state_next == ST_EXECUTE) && (cur_ctrl.cls == CLS_BRANCH);
            if (sel_live) begin
                a_sel_reg   <= cur_ctrl.a_sel;
                b_sel_reg   <= cur_ctrl.b_sel;
                imm_sel_reg <= IMM_SEL_W'(cur_ctrl.imm_sel);
                npc_sel_reg <= cur_ctrl.npc_sel;
                alu_op_reg  <= ALU_OP_W'(cur_ctrl.alu_op);
            end else begin
                a_sel_reg   <= '0;
                b_sel_reg   <= 1'b0;
                imm_sel_reg <= '0;
                npc_sel_reg <= '0;
                alu_op_reg  <= '0;
            end
            illegal_reg   <= illegal_reg | decode_illegal;
            mem_fault_reg <= mem_fault_reg | timeout_fault;
            busy_reg      <= (state_next != ST_FETCH);
        end
    end

`ifdef RV32M_EN
    logic mul_start_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_start_reg <= 1'b0;
        end else begin
            mul_start_reg <= (state_reg == ST_EXECUTE) && (state_next == ST_MULWAIT);
        end
    end

    assign mul_start = mul_start_reg;
`else
    logic unused_mul_done;
    assign unused_mul_done = mul_done;
    assign mul_start       = 1'b0;
`endif

    // The IR must capture the word in the very cycle imem presents it.
    assign ir_write                = (state_reg == ST_FETCH) && imem_ready && !rst;
    assign imem_req                = imem_req_reg;
    assign pc_write                = pc_write_reg;
    assign write                   = write_reg;
    assign load                    = load_reg;
    assign store                   = store_reg;
    assign branch                  = branch_reg;
    assign alu_operand_a_selector  = a_sel_reg;
    assign alu_operand_b_selector  = b_sel_reg;
    assign immediate_selector      = imm_sel_reg;
    assign next_pc_selector        = npc_sel_reg;
    assign alu_operations_selector = alu_op_reg;
    assign illegal_instr           = illegal_reg;
    assign mem_fault               = mem_fault_reg;
    assign busy                    = busy_reg;

endmodule
